// File: rtl/bp_mc_mmio_responder.sv
// bp_mc_mmio_responder
//   Bridges manycore MMIO requests (EPA word addresses) onto the BP I/O
//   command/response channel. At most one request is in flight. The FSM runs
//   IDLE -> SEND -> WAIT -> REPLY -> IDLE. Decode errors and stores with
//   unsupported byte masks are answered locally and never reach BP.
//
//   Optional feature: define BP_MC_MMIO_RESPONDER_TIMEOUT_EN to add a WAIT
//   timeout (timeout_p cycles). Without it WAIT holds until a response arrives.
//
// Ports
//   clk_i, reset_n_i      clock, async active-low reset
//   in_*                  manycore request (valid/yumi handshake)
//   returning_*           one-cycle response strobe + data
//   io_cmd_*              BP command (valid/ready)
//   io_resp_*             BP response (valid/yumi)
//   err_cnt_o             saturating count of errors / stray responses
module bp_mc_mmio_responder #(
    parameter int mc_data_width_p = 32,
    parameter int mc_addr_width_p = 28,
    parameter int paddr_width_p   = 40,
    parameter logic [paddr_width_p-1:0] cfg_base_p     = 40'h0020_0000,
    parameter logic [paddr_width_p-1:0] clint_base_p   = 40'h0030_0000,
    parameter logic [paddr_width_p-1:0] ucode_offset_p = 40'h0000_8000,
    parameter int timeout_p = 1024
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       in_v_i,
    input  logic                       in_we_i,
    input  logic [mc_addr_width_p-1:0] in_addr_i,
    input  logic [mc_data_width_p-1:0] in_data_i,
    input  logic [3:0]                 in_mask_i,
    input  logic [4:0]                 in_load_info_i,
    output logic                       in_yumi_o,
    output logic [mc_data_width_p-1:0] returning_data_o,
    output logic                       returning_v_o,
    output logic                       io_cmd_v_o,
    input  logic                       io_cmd_ready_i,
    output logic                       io_cmd_we_o,
    output logic [paddr_width_p-1:0]   io_cmd_addr_o,
    output logic [1:0]                 io_cmd_size_o,
    output logic [63:0]                io_cmd_data_o,
    input  logic                       io_resp_v_i,
    input  logic [63:0]                io_resp_data_i,
    output logic                       io_resp_yumi_o,
    output logic [7:0]                 err_cnt_o
);
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_REPLY} state_e;
    state_e state;

    // Goes high on the first clock edge after reset release; gates the
    // combinational handshake outputs so they stay low while in reset.
    logic       live;
    logic       req_we;
    logic [4:0] req_info;

    assign in_yumi_o      = live && (state == S_IDLE) && in_v_i;
    // Responses are always consumed; outside WAIT they are dropped as errors.
    assign io_resp_yumi_o = live && io_resp_v_i;

    // ---- request decode ----
    logic [3:0]  dev;
    logic [11:0] woff;
    logic        dev_ok;
    logic [paddr_width_p-1:0] base, waddr;
    assign dev  = in_addr_i[15:12];
    assign woff = in_addr_i[11:0];

    always_comb begin
        dev_ok = 1'b1;
        base   = cfg_base_p;
        case (dev)
            4'd0:    base = cfg_base_p;
            4'd1:    base = cfg_base_p + ucode_offset_p;
            4'd2:    base = clint_base_p;
            default: begin base = '0; dev_ok = 1'b0; end
        endcase
    end
    assign waddr = base + paddr_width_p'({woff, 2'b00});

    // Store mask -> size / byte offset / lane-replicated data.
    logic        st_ok;
    logic [1:0]  st_size, st_boff;
    logic [63:0] st_data;
    always_comb begin
        st_ok   = 1'b1;
        st_size = 2'd2;
        st_boff = 2'd0;
        st_data = {2{in_data_i}};
        if (!in_we_i) begin
            st_data = '0;
        end else begin
            case (in_mask_i)
                4'hF: ;
                4'h1: begin st_size = 2'd0; st_boff = 2'd0; st_data = {8{in_data_i[7:0]}};   end
                4'h2: begin st_size = 2'd0; st_boff = 2'd1; st_data = {8{in_data_i[15:8]}};  end
                4'h4: begin st_size = 2'd0; st_boff = 2'd2; st_data = {8{in_data_i[23:16]}}; end
                4'h8: begin st_size = 2'd0; st_boff = 2'd3; st_data = {8{in_data_i[31:24]}}; end
                4'h3: begin st_size = 2'd1; st_boff = 2'd0; st_data = {4{in_data_i[15:0]}};  end
                4'hC: begin st_size = 2'd1; st_boff = 2'd2; st_data = {4{in_data_i[31:16]}}; end
                default: st_ok = 1'b0;
            endcase
        end
    end

    // ---- load data extraction (info = {unsigned, byte, hex, part_sel}) ----
    logic [31:0] rw, ld_data;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic        ld_sx;
    assign rw    = io_resp_data_i[31:0];
    assign ld_b  = rw[{req_info[1:0], 3'b000} +: 8];
    assign ld_h  = rw[{req_info[1], 4'b0000} +: 16];
    assign ld_sx = ~req_info[4];
    always_comb begin
        if (req_info[3])      ld_data = {{24{ld_sx & ld_b[7]}}, ld_b};
        else if (req_info[2]) ld_data = {{16{ld_sx & ld_h[15]}}, ld_h};
        else                  ld_data = rw;
    end

    // ---- error accounting ----
    logic e_dec, e_stray, e_to;
    logic [8:0] err_sum;
    assign e_dec   = in_yumi_o && (!dev_ok || (in_we_i && !st_ok));
    assign e_stray = io_resp_yumi_o && (state != S_WAIT);

`ifdef BP_MC_MMIO_RESPONDER_TIMEOUT_EN
    localparam int TW = $clog2(timeout_p + 1);
    logic [TW-1:0] tcnt;
    assign e_to = (state == S_WAIT) && !io_resp_v_i && (tcnt == TW'(timeout_p - 1));
`else
    assign e_to = 1'b0;
`endif

    // Stray response and decode error can land in the same cycle.
    assign err_sum = {1'b0, err_cnt_o} + 9'(e_dec) + 9'(e_stray) + 9'(e_to);

    logic unused_ok;
    assign unused_ok = &{1'b0, in_addr_i, io_resp_data_i[63:32]};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state            <= S_IDLE;
            live             <= 1'b0;
            req_we           <= 1'b0;
            req_info         <= '0;
            returning_data_o <= '0;
            returning_v_o    <= 1'b0;
            io_cmd_v_o       <= 1'b0;
            io_cmd_we_o      <= 1'b0;
            io_cmd_addr_o    <= '0;
            io_cmd_size_o    <= '0;
            io_cmd_data_o    <= '0;
            err_cnt_o        <= '0;
`ifdef BP_MC_MMIO_RESPONDER_TIMEOUT_EN
            tcnt             <= '0;
`endif
        end else begin
            live          <= 1'b1;
            err_cnt_o     <= err_sum[8] ? 8'hFF : err_sum[7:0];
            returning_v_o <= 1'b0;
            case (state)
                S_IDLE: if (in_yumi_o) begin
                    req_we   <= in_we_i;
                    req_info <= in_load_info_i;
                    if (e_dec) begin
                        state            <= S_REPLY;
                        returning_v_o    <= 1'b1;
                        returning_data_o <= (in_we_i || dev_ok) ? 32'd0 : ERR_DATA;
                    end else begin
                        state         <= S_SEND;
                        io_cmd_v_o    <= 1'b1;
                        io_cmd_we_o   <= in_we_i;
                        io_cmd_addr_o <= waddr + paddr_width_p'(st_boff);
                        io_cmd_size_o <= st_size;
                        io_cmd_data_o <= st_data;
                    end
                end
                S_SEND: if (io_cmd_ready_i) begin
                    io_cmd_v_o <= 1'b0;
                    state      <= S_WAIT;
`ifdef BP_MC_MMIO_RESPONDER_TIMEOUT_EN
                    tcnt       <= '0;
`endif
                end
                S_WAIT: begin
                    if (io_resp_v_i) begin
                        state            <= S_REPLY;
                        returning_v_o    <= 1'b1;
                        returning_data_o <= req_we ? 32'd0 : ld_data;
                    end
`ifdef BP_MC_MMIO_RESPONDER_TIMEOUT_EN
                    else if (e_to) begin
                        state            <= S_REPLY;
                        returning_v_o    <= 1'b1;
                        returning_data_o <= req_we ? 32'd0 : ERR_DATA;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bp_mc_mmio_responder.sv
module tb_bp_mc_mmio_responder;
    localparam int TO = 16;

    logic        clk_i = 1'b0, reset_n_i = 1'b0;
    logic        in_v_i = 0, in_we_i = 0;
    logic [27:0] in_addr_i = '0;
    logic [31:0] in_data_i = '0;
    logic [3:0]  in_mask_i = '0;
    logic [4:0]  in_load_info_i = '0;
    logic        in_yumi_o;
    logic [31:0] returning_data_o;
    logic        returning_v_o;
    logic        io_cmd_v_o, io_cmd_ready_i = 0, io_cmd_we_o;
    logic [39:0] io_cmd_addr_o;
    logic [1:0]  io_cmd_size_o;
    logic [63:0] io_cmd_data_o;
    logic        io_resp_v_i = 0;
    logic [63:0] io_resp_data_i = '0;
    logic        io_resp_yumi_o;
    logic [7:0]  err_cnt_o;

    bp_mc_mmio_responder #(.timeout_p(TO)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .in_v_i(in_v_i), .in_we_i(in_we_i), .in_addr_i(in_addr_i),
        .in_data_i(in_data_i), .in_mask_i(in_mask_i), .in_load_info_i(in_load_info_i),
        .in_yumi_o(in_yumi_o), .returning_data_o(returning_data_o), .returning_v_o(returning_v_o),
        .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i), .io_cmd_we_o(io_cmd_we_o),
        .io_cmd_addr_o(io_cmd_addr_o), .io_cmd_size_o(io_cmd_size_o), .io_cmd_data_o(io_cmd_data_o),
        .io_resp_v_i(io_resp_v_i), .io_resp_data_i(io_resp_data_i), .io_resp_yumi_o(io_resp_yumi_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;
    int exp_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void bump_err();
        if (exp_err < 255) exp_err++;
    endfunction

    // Reference: load extraction from a 32-bit response word.
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [4:0] info);
        logic [31:0] r;
        int ps;
        ps = int'(info[1:0]);
        if (info[3]) begin
            r = (word >> (8 * ps)) & 32'hFF;
            if (!info[4] && r >= 32'h80) r = r - 32'd256;
        end else if (info[2]) begin
            r = (word >> (16 * (ps / 2))) & 32'hFFFF;
            if (!info[4] && r >= 32'h8000) r = r - 32'h10000;
        end else begin
            r = word;
        end
        return r;
    endfunction

    // Reference: what BP command a request should produce.
    task automatic ref_cmd(input logic [3:0] dev, input logic [11:0] w, input logic we,
                           input logic [31:0] d, input logic [3:0] m,
                           output logic ok, output logic [39:0] a,
                           output logic [1:0] sz, output logic [63:0] cd);
        logic [39:0] base;
        int idx;
        ok   = (dev <= 2);
        base = (dev == 0) ? 40'h20_0000 : (dev == 1) ? 40'h20_8000 : 40'h30_0000;
        a    = base + 40'(w) * 4;
        sz   = 2;
        cd   = 64'(d) * 64'h0000_0001_0000_0001;
        if (we && m != 4'hF) begin
            if ($countones(m) == 1) begin
                idx = $clog2(m);
                sz  = 0;
                a   = a + 40'(idx);
                cd  = 64'((d >> (8 * idx)) & 32'hFF) * 64'h0101_0101_0101_0101;
            end else if (m == 4'h3) begin
                sz = 1;
                cd = 64'(d & 32'hFFFF) * 64'h0001_0001_0001_0001;
            end else if (m == 4'hC) begin
                sz = 1;
                a  = a + 2;
                cd = 64'(d >> 16) * 64'h0001_0001_0001_0001;
            end else begin
                ok = 0;
            end
        end
    endtask

    // One full request; rdy_dly = cycles io_cmd_ready_i is held low while
    // the command is valid, resp_dly = idle WAIT cycles before the response.
    task automatic txn(input logic [3:0] dev, input logic [11:0] w, input logic we,
                       input logic [31:0] d, input logic [3:0] m, input logic [4:0] info,
                       input logic [31:0] rword, input int rdy_dly, input int resp_dly);
        logic ok, timed_out, got;
        logic [39:0] ea;
        logic [1:0]  esz;
        logic [63:0] ecd;
        logic [31:0] edata;
        int exp_t, t_ret, nseen, t_sent;
        logic sent, rdone;
        ref_cmd(dev, w, we, d, m, ok, ea, esz, ecd);
`ifdef BP_MC_MMIO_RESPONDER_TIMEOUT_EN
        timed_out = ok && (resp_dly >= TO);
`else
        timed_out = 0;
`endif
        if (!ok)            begin edata = (we || dev <= 2) ? 32'd0 : 32'hDEAD_BEEF; exp_t = 1; end
        else if (timed_out) begin edata = we ? 32'd0 : 32'hDEAD_BEEF; exp_t = 2 + rdy_dly + TO; end
        else                begin edata = we ? 32'd0 : ref_load(rword, info); exp_t = 3 + rdy_dly + resp_dly; end

        @(posedge clk_i); #1;
        in_v_i = 1; in_we_i = we; in_addr_i = {12'($urandom), dev, w};
        in_data_i = d; in_mask_i = m; in_load_info_i = info;
        @(negedge clk_i);
        chk("yumi", in_yumi_o, 1);
        nseen = 0; sent = 0; rdone = 0; got = 0; t_ret = -1; t_sent = 0;
        for (int cyc = 1; cyc < 300; cyc++) begin
            @(posedge clk_i); #1;
            in_v_i = 0;
            io_cmd_ready_i = (nseen >= rdy_dly);
            io_resp_v_i = sent && !rdone && (cyc - t_sent - 1 >= resp_dly);
            io_resp_data_i = {$urandom, rword};
            @(negedge clk_i);
            if (io_cmd_v_o) begin
                chk("cmd_we", io_cmd_we_o, we);
                chk("cmd_addr", io_cmd_addr_o, ea);
                chk("cmd_size", io_cmd_size_o, esz);
                if (we) chk("cmd_data", io_cmd_data_o, ecd);
                if (io_cmd_ready_i) begin sent = 1; t_sent = cyc; end
                nseen++;
            end
            if (io_resp_v_i) begin
                chk("resp_yumi", io_resp_yumi_o, 1);
                rdone = 1;
            end
            if (returning_v_o) begin
                got = 1; t_ret = cyc;
                chk("ret_data", returning_data_o, edata);
                break;
            end
        end
        chk("ret_seen", got, 1);
        chk("latency", t_ret, exp_t);
        if (!ok) chk("no_cmd", nseen, 0);
        @(posedge clk_i); #1;
        io_cmd_ready_i = 0; io_resp_v_i = 0;
        @(negedge clk_i);
        chk("ret_one_cycle", returning_v_o, 0);
        if (!ok || timed_out) bump_err();
        chk("err_cnt", err_cnt_o, exp_err);
    endtask

    // Responses with nothing outstanding: accepted and counted as errors.
    task automatic stray(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            io_resp_v_i = 1; io_resp_data_i = {$urandom, $urandom};
            @(negedge clk_i);
            chk("stray_yumi", io_resp_yumi_o, 1);
            bump_err();
        end
        @(posedge clk_i); #1;
        io_resp_v_i = 0;
        @(negedge clk_i);
        chk("stray_err", err_cnt_o, exp_err);
        chk("stray_no_ret", returning_v_o, 0);
    endtask

    initial begin
        logic [3:0] mpool [8];
        mpool = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h6};

        // reset state, with requests/responses presented during reset
        in_v_i = 1; io_resp_v_i = 1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_yumi", in_yumi_o, 0);
        chk("rst_resp_yumi", io_resp_yumi_o, 0);
        chk("rst_ret_v", returning_v_o, 0);
        chk("rst_cmd_v", io_cmd_v_o, 0);
        chk("rst_err", err_cnt_o, 0);
        chk("rst_ret_data", returning_data_o, 0);
        in_v_i = 0; io_resp_v_i = 0;
        reset_n_i = 1;
        @(negedge clk_i);
        chk("post_rst_err", err_cnt_o, 0);

        // directed
        txn(4'd0, 12'd3, 0, 32'h0, 4'h0, 5'b00000, 32'h1234_5678, 0, 0);
        txn(4'd0, 12'd9, 0, 32'h0, 4'h0, 5'b01010, 32'h0080_0000, 0, 0);
        txn(4'd0, 12'd9, 0, 32'h0, 4'h0, 5'b11010, 32'h0080_0000, 0, 0);
        txn(4'd1, 12'd5, 0, 32'h0, 4'h0, 5'b00110, 32'h8001_7FFF, 1, 2);
        txn(4'd2, 12'd1, 1, 32'h00AB_0000, 4'h4, 5'b00000, 32'h0, 0, 0);
        txn(4'd2, 12'hFFF, 1, 32'hCAFE_F00D, 4'hC, 5'b00000, 32'h0, 0, 1);
        txn(4'd5, 12'd7, 0, 32'h0, 4'h0, 5'b00000, 32'h0, 0, 0);
        txn(4'd0, 12'd2, 1, 32'h1111_2222, 4'h5, 5'b00000, 32'h0, 0, 0);
        txn(4'd0, 12'd4, 1, 32'h1111_2222, 4'h0, 5'b00000, 32'h0, 0, 0);
        txn(4'd15, 12'd4, 1, 32'h1111_2222, 4'hF, 5'b00000, 32'h0, 0, 0);
        txn(4'd0, 12'd8, 1, 32'h89AB_CDEF, 4'hF, 5'b00000, 32'h0, 10, 0);
        stray(3);

        // reset pulse while a load waits for its response
        @(posedge clk_i); #1;
        in_v_i = 1; in_we_i = 0; in_addr_i = 28'h0000_007; io_cmd_ready_i = 1;
        @(posedge clk_i); #1;
        in_v_i = 0;
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 0;
        #1;
        chk("arst_cmd_v", io_cmd_v_o, 0);
        chk("arst_ret_v", returning_v_o, 0);
        chk("arst_err", err_cnt_o, 0);
        chk("arst_cmd_addr", io_cmd_addr_o, 0);
        exp_err = 0;
        io_cmd_ready_i = 0;
        @(negedge clk_i);
        reset_n_i = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("arst_no_ret", returning_v_o, 0);
            chk("arst_idle_cmd", io_cmd_v_o, 0);
        end

`ifdef BP_MC_MMIO_RESPONDER_TIMEOUT_EN
        txn(4'd0, 12'd1, 0, 32'h0, 4'h0, 5'b00000, 32'h0, 0, 1000);
        stray(1);
        chk("timeout_err2", err_cnt_o, 2);
        txn(4'd2, 12'd1, 1, 32'h5, 4'hF, 5'b00000, 32'h0, 2, 1000);
`endif

        // randomized
        for (int i = 0; i < 60; i++) begin
            logic we;
            logic [3:0] m;
            we = 1'($urandom);
            m  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : mpool[$urandom_range(0, 7)];
            txn(4'($urandom_range(0, 4)), 12'($urandom), we, $urandom, m, 5'($urandom),
                $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // saturation
        stray(260);
        chk("err_sat", err_cnt_o, 8'hFF);
        txn(4'd7, 12'd0, 0, 32'h0, 4'h0, 5'b00000, 32'h0, 0, 0);
        chk("err_sat_hold", err_cnt_o, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_mc_mmio_responder.md
BP_MC_MMIO_RESPONDER -- requirements
Module: bp_mc_mmio_responder

Interface
REQ-001 SHALL have parameter mc_data_width_p, default 32, manycore word width (only 32 supported).
REQ-002 SHALL have parameter mc_addr_width_p, default 28, manycore EPA word-address width.
REQ-003 SHALL have parameter paddr_width_p, default 40, BP physical address width.
REQ-004 SHALL have parameters cfg_base_p, default 40'h0020_0000, and clint_base_p, default 40'h0030_0000, device bases.
REQ-005 SHALL have parameter ucode_offset_p, default 40'h0000_8000, CCE ucode offset added to cfg_base_p.
REQ-006 SHALL have parameter timeout_p, default 1024, wait-state cycle limit (used only per REQ-030).
REQ-007 Ports: clk_i  in  1  clock; reset_n_i  in  1  reset, asynchronous and active-low.
REQ-008 Ports: in_v_i in 1 request valid; in_we_i in 1 store; in_addr_i in mc_addr_width_p EPA; in_data_i in 32 store data; in_mask_i in 4 byte mask.
REQ-009 Ports: in_load_info_i in 5 {is_unsigned_op, is_byte_op, is_hex_op, part_sel[1:0]}; in_yumi_o out 1 request consumed.
REQ-010 Ports: returning_data_o out 32 response data; returning_v_o out 1 one-cycle response strobe (sink always accepts).
REQ-011 Ports: io_cmd_v_o out 1; io_cmd_ready_i in 1; io_cmd_we_o out 1; io_cmd_addr_o out paddr_width_p; io_cmd_size_o out 2 (log2 bytes); io_cmd_data_o out 64.
REQ-012 Ports: io_resp_v_i in 1; io_resp_data_i in 64; io_resp_yumi_o out 1; err_cnt_o out 8 saturating error count.

Function
REQ-013 SHALL implement FSM IDLE -> SEND -> WAIT -> REPLY -> IDLE; one request outstanding at most.
REQ-014 IDLE: when in_v_i=1, SHALL assert in_yumi_o same cycle, register request, go to SEND (or REPLY for REQ-019/REQ-020).
REQ-015 Decode in_addr_i[15:12] as dev, [11:0] as word offset w: dev 0 -> cfg_base_p+4w; dev 1 -> cfg_base_p+ucode_offset_p+4w; dev 2 -> clint_base_p+4w.
REQ-016 Loads SHALL issue io_cmd_we_o=0, size 2 (4 bytes), word-aligned address.
REQ-017 Stores with mask 4'hF SHALL issue size 2; one-hot mask size 0, address +byte index; 4'h3/4'hC size 1, address +0/+2; data replicated across io_cmd_data_o lanes.
REQ-018 SEND: io_cmd_v_o=1 with stable fields until io_cmd_ready_i=1, then WAIT.
REQ-019 Dev >2 SHALL skip BP, go to REPLY with data 32'hDEAD_BEEF for loads, 0 for stores, increment err_cnt_o.
REQ-020 Stores with any other mask (incl. 0) SHALL be dropped, go to REPLY with data 0, increment err_cnt_o.
REQ-021 WAIT: io_resp_yumi_o = io_resp_v_i; on accept capture data, go to REPLY.
REQ-022 Load data SHALL be extracted from io_resp_data_i[31:0]: byte op lane part_sel, hex op half part_sel[1], sign-extended unless is_unsigned_op; word op unmodified.
REQ-023 Store responses SHALL return data 0.
REQ-024 REPLY: returning_v_o=1 for exactly one cycle with returning_data_o, then IDLE; new request accepted earliest next cycle.
REQ-025 Minimum load latency in_yumi_o -> returning_v_o SHALL be 3 cycles (ready and response immediate).
REQ-026 io_resp_v_i outside WAIT SHALL be accepted (yumi) and discarded, counted in err_cnt_o.
REQ-027 err_cnt_o SHALL saturate at 8'hFF.

Reset
REQ-028 On reset_n_i=0, SHALL asynchronously force IDLE, err_cnt_o=0, all valid/yumi outputs 0, data outputs 0; in-flight request abandoned without response.
REQ-029 SHALL leave reset synchronously on first clk_i edge after reset_n_i rises.

Configuration
REQ-030 With BP_MC_MMIO_RESPONDER_TIMEOUT_EN defined, a counter cleared on WAIT entry SHALL, after timeout_p cycles without io_resp_v_i, go to REPLY with 32'hDEAD_BEEF (load) or 0 (store) and increment err_cnt_o; late responses follow REQ-026.
REQ-031 Without BP_MC_MMIO_RESPONDER_TIMEOUT_EN, WAIT SHALL wait indefinitely; no counter logic present.

Verification
REQ-032 Load dev0 w=3, resp 64'h0000_0000_1234_5678 -> io_cmd_addr_o=0x20000C, size 2; returning_data_o=0x12345678, 3 cycles after yumi.
REQ-033 Signed byte load part_sel=2, resp word 0x0080_0000 -> 0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-034 Store dev2 w=1 mask 4'h4 data 0x00AB_0000 -> addr 0x300006, size 0, io_cmd_we_o=1; returning_data_o=0.
REQ-035 Load dev 5 -> no io_cmd_v_o; returning_data_o=0xDEADBEEF; err_cnt_o=1; store mask 4'h5 -> err_cnt_o=2.
REQ-036 io_cmd_ready_i held 0 for 10 cycles -> fields stable; reset_n_i pulsed in WAIT -> IDLE, no returning_v_o.
REQ-037 TIMEOUT_EN, timeout_p=16, no response -> returning_data_o=0xDEADBEEF 16 cycles after WAIT entry; later io_resp_v_i dropped, err_cnt_o=2.
